// File: rtl/escritor_pixeles.sv
// Packs SIMD lane results into memory words through a 2-entry buffer and writes them
// sequentially from base_addr. A single-step mode freezes every register until paso pulses.
module escritor_pixeles #(
    parameter int LANES  = 4,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 modo_paso,
    input  logic                 paso,
    input  logic                 iniciar,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [CNT_W-1:0]     total_pixeles,
    input  logic                 listo_in,
    input  logic [8*LANES-1:0]   pixel_in,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [8*LANES-1:0]   mem_wdata,
    output logic [LANES-1:0]     mem_be,
    input  logic                 mem_ready,
    output logic                 ocupado,
    output logic                 lleno,
    output logic                 terminado,
    output logic                 desborde,
    output logic [CNT_W-1:0]     pixeles_escritos
);

    typedef enum logic [1:0] {IDLE, ACTIVO, FIN} estado_t;

    estado_t              estado_q, estado_d;
    logic [8*LANES-1:0]   slot0_q, slot0_d;
    logic [8*LANES-1:0]   slot1_q, slot1_d;
    logic [1:0]           count_q, count_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [CNT_W-1:0]     restantes_q, restantes_d;
    logic [CNT_W-1:0]     escritos_q, escritos_d;
    logic                 desborde_q, desborde_d;

    logic                 ce;
    logic                 activo;
    logic                 pop;
    logic                 push;
    logic [CNT_W-1:0]     paso_n;

    assign ce     = !modo_paso | paso;
    assign activo = (estado_q == ACTIVO);
    assign mem_we = activo && (count_q != 2'd0);
    // A handshake only counts when registers are allowed to advance.
    assign pop    = ce && mem_we && mem_ready;
    assign push   = ce && activo && listo_in && ((count_q != 2'd2) || pop);
    assign paso_n = (restantes_q < CNT_W'(LANES)) ? restantes_q : CNT_W'(LANES);

    assign mem_addr         = addr_q;
    assign mem_wdata        = slot0_q;
    assign ocupado          = (estado_q != IDLE);
    assign lleno            = (count_q == 2'd2);
    assign terminado        = (estado_q == FIN);
    assign desborde         = desborde_q;
    assign pixeles_escritos = escritos_q;

    // k < min(LANES, restantes) reduces to k < restantes since k is already below LANES.
    always_comb begin
        mem_be = '0;
        for (int k = 0; k < LANES; k++) begin
            mem_be[k] = (CNT_W'(k) < restantes_q);
        end
    end

    always_comb begin
        estado_d    = estado_q;
        slot0_d     = slot0_q;
        slot1_d     = slot1_q;
        count_d     = count_q;
        addr_d      = addr_q;
        restantes_d = restantes_q;
        escritos_d  = escritos_q;
        desborde_d  = desborde_q;
        if (ce) begin
            case (estado_q)
                IDLE: begin
                    if (iniciar) begin
                        addr_d      = base_addr;
                        restantes_d = total_pixeles;
                        escritos_d  = '0;
                        count_d     = 2'd0;
                        desborde_d  = 1'b0;
                        estado_d    = (total_pixeles == '0) ? FIN : ACTIVO;
                    end
                end
                ACTIVO: begin
                    if (listo_in && (count_q == 2'd2) && !pop) begin
                        desborde_d = 1'b1;
                    end
                    if (pop) begin
                        slot0_d     = slot1_q;
                        count_d     = count_q - 2'd1;
                        addr_d      = addr_q + ADDR_W'(1);
                        restantes_d = restantes_q - paso_n;
                        escritos_d  = escritos_q + paso_n;
                    end
                    // Push lands in whichever slot is the tail after any pop this cycle.
                    if (push) begin
                        if (count_d == 2'd0) begin
                            slot0_d = pixel_in;
                        end else begin
                            slot1_d = pixel_in;
                        end
                        count_d = count_d + 2'd1;
                    end
                    if (pop && (restantes_q == paso_n)) begin
                        count_d  = 2'd0;
                        estado_d = FIN;
                    end
                end
                FIN: begin
                    estado_d = IDLE;
                end
                default: begin
                    estado_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= IDLE;
            slot0_q     <= '0;
            slot1_q     <= '0;
            count_q     <= 2'd0;
            addr_q      <= '0;
            restantes_q <= '0;
            escritos_q  <= '0;
            desborde_q  <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            slot0_q     <= slot0_d;
            slot1_q     <= slot1_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            restantes_q <= restantes_d;
            escritos_q  <= escritos_d;
            desborde_q  <= desborde_d;
        end
    end

endmodule

// File: tb/tb_escritor_pixeles.sv
// Directed bench for escritor_pixeles: packing, partial last word, overflow, stepping,
// empty job and mid-job reset.
module tb_escritor_pixeles;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         modo_paso;
    logic         paso;
    logic         iniciar;
    logic [15:0]  base_addr;
    logic [19:0]  total_pixeles;
    logic         listo_in;
    logic [31:0]  pixel_in;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_be;
    logic         mem_ready;
    logic         ocupado;
    logic         lleno;
    logic         terminado;
    logic         desborde;
    logic [19:0]  pixeles_escritos;

    int checks = 0;
    int errors = 0;

    escritor_pixeles #(.LANES(4), .ADDR_W(16), .CNT_W(20)) dut (
        .clk(clk), .rst_n(rst_n), .modo_paso(modo_paso), .paso(paso), .iniciar(iniciar),
        .base_addr(base_addr), .total_pixeles(total_pixeles), .listo_in(listo_in),
        .pixel_in(pixel_in), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .ocupado(ocupado), .lleno(lleno),
        .terminado(terminado), .desborde(desborde), .pixeles_escritos(pixeles_escritos)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [15:0] base, input logic [19:0] total);
        base_addr     = base;
        total_pixeles = total;
        iniciar       = 1'b1;
        tick();
        iniciar       = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; modo_paso = 1'b0; paso = 1'b0; iniciar = 1'b0;
        base_addr = '0; total_pixeles = '0; listo_in = 1'b0; pixel_in = '0; mem_ready = 1'b0;
        #3;
        chk("rst_we",   64'(mem_we), 64'(0));
        chk("rst_ocup", 64'(ocupado), 64'(0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        chk("rst_be",   64'(mem_be), 64'(0));
        chk("rst_wd",   64'(mem_wdata), 64'(0));
        tick(); tick();
        rst_n = 1'b1;

        // Full two-word job
        start_job(16'h0100, 20'd8);
        chk("t1_ocup", 64'(ocupado), 64'(1));
        chk("t1_we0",  64'(mem_we), 64'(0));
        listo_in = 1'b1; pixel_in = 32'h04030201; mem_ready = 1'b1;
        tick();
        pixel_in = 32'h08070605;
        chk("t1_we1",   64'(mem_we), 64'(1));
        chk("t1_addr1", 64'(mem_addr), 64'(16'h0100));
        chk("t1_wd1",   64'(mem_wdata), 64'(32'h04030201));
        chk("t1_be1",   64'(mem_be), 64'(4'b1111));
        tick();
        listo_in = 1'b0;
        chk("t1_we2",   64'(mem_we), 64'(1));
        chk("t1_addr2", 64'(mem_addr), 64'(16'h0101));
        chk("t1_wd2",   64'(mem_wdata), 64'(32'h08070605));
        chk("t1_be2",   64'(mem_be), 64'(4'b1111));
        chk("t1_cnt4",  64'(pixeles_escritos), 64'(4));
        tick();
        chk("t1_term",  64'(terminado), 64'(1));
        chk("t1_we3",   64'(mem_we), 64'(0));
        chk("t1_cnt8",  64'(pixeles_escritos), 64'(8));
        tick();
        chk("t1_term_off", 64'(terminado), 64'(0));
        chk("t1_idle",     64'(ocupado), 64'(0));

        // Partial last word
        start_job(16'h0200, 20'd6);
        listo_in = 1'b1; pixel_in = 32'h04030201;
        tick();
        pixel_in = 32'h0C0B0A09;
        chk("t2_be1", 64'(mem_be), 64'(4'b1111));
        tick();
        listo_in = 1'b0;
        chk("t2_addr2", 64'(mem_addr), 64'(16'h0201));
        chk("t2_wd2",   64'(mem_wdata), 64'(32'h0C0B0A09));
        chk("t2_be2",   64'(mem_be), 64'(4'b0011));
        tick();
        chk("t2_term", 64'(terminado), 64'(1));
        chk("t2_cnt6", 64'(pixeles_escritos), 64'(6));
        tick();
        chk("t2_term_off1", 64'(terminado), 64'(0));
        tick();
        chk("t2_term_off2", 64'(terminado), 64'(0));

        // Overflow with memory stalled
        mem_ready = 1'b0;
        start_job(16'h0300, 20'd8);
        listo_in = 1'b1; pixel_in = 32'hA0A0A0A0;
        tick();
        chk("t3_lleno1", 64'(lleno), 64'(0));
        pixel_in = 32'hB0B0B0B0;
        tick();
        chk("t3_lleno2", 64'(lleno), 64'(1));
        chk("t3_desb0",  64'(desborde), 64'(0));
        pixel_in = 32'hC0C0C0C0;
        tick();
        listo_in = 1'b0;
        chk("t3_desb1",  64'(desborde), 64'(1));
        chk("t3_lleno3", 64'(lleno), 64'(1));
        chk("t3_head",   64'(mem_wdata), 64'(32'hA0A0A0A0));
        base_addr = 16'h0999; total_pixeles = 20'd1; iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("t3_ign_addr", 64'(mem_addr), 64'(16'h0300));
        chk("t3_ign_desb", 64'(desborde), 64'(1));
        mem_ready = 1'b1;
        chk("t3_we1",   64'(mem_we), 64'(1));
        tick();
        chk("t3_addr2", 64'(mem_addr), 64'(16'h0301));
        chk("t3_wd2",   64'(mem_wdata), 64'(32'hB0B0B0B0));
        tick();
        chk("t3_term",  64'(terminado), 64'(1));
        chk("t3_we3",   64'(mem_we), 64'(0));
        chk("t3_desb2", 64'(desborde), 64'(1));
        tick();
        chk("t3_desb_idle", 64'(desborde), 64'(1));

        // Single-step mode
        start_job(16'h0400, 20'd8);
        chk("t4_desb_clr", 64'(desborde), 64'(0));
        listo_in = 1'b1; pixel_in = 32'h11223344;
        tick();
        listo_in = 1'b0;
        modo_paso = 1'b1; paso = 1'b0;
        chk("t4_we",   64'(mem_we), 64'(1));
        tick(); tick(); tick();
        chk("t4_hold_we",   64'(mem_we), 64'(1));
        chk("t4_hold_addr", 64'(mem_addr), 64'(16'h0400));
        chk("t4_hold_wd",   64'(mem_wdata), 64'(32'h11223344));
        chk("t4_hold_cnt",  64'(pixeles_escritos), 64'(0));
        paso = 1'b1;
        tick();
        paso = 1'b0;
        chk("t4_step_addr", 64'(mem_addr), 64'(16'h0401));
        chk("t4_step_cnt",  64'(pixeles_escritos), 64'(4));
        chk("t4_step_we",   64'(mem_we), 64'(0));
        tick();
        chk("t4_frozen_addr", 64'(mem_addr), 64'(16'h0401));
        modo_paso = 1'b0;
        listo_in = 1'b1; pixel_in = 32'h55667788;
        tick();
        listo_in = 1'b0;
        chk("t4_addr2", 64'(mem_addr), 64'(16'h0401));
        tick();
        chk("t4_term", 64'(terminado), 64'(1));
        tick();

        // Empty job
        start_job(16'h0500, 20'd0);
        chk("t5_term", 64'(terminado), 64'(1));
        chk("t5_ocup", 64'(ocupado), 64'(1));
        chk("t5_we",   64'(mem_we), 64'(0));
        listo_in = 1'b1; pixel_in = 32'hDEADBEEF;
        tick();
        listo_in = 1'b0;
        chk("t5_idle",  64'(ocupado), 64'(0));
        chk("t5_term0", 64'(terminado), 64'(0));
        chk("t5_desb",  64'(desborde), 64'(0));
        chk("t5_lleno", 64'(lleno), 64'(0));

        // Reset mid-job
        start_job(16'h0600, 20'd8);
        listo_in = 1'b1; pixel_in = 32'h01010101;
        tick();
        pixel_in = 32'h02020202;
        tick();
        listo_in = 1'b0;
        chk("t6_addr_pre", 64'(mem_addr), 64'(16'h0601));
        rst_n = 1'b0;
        #1;
        chk("t6_we",   64'(mem_we), 64'(0));
        chk("t6_ocup", 64'(ocupado), 64'(0));
        chk("t6_addr", 64'(mem_addr), 64'(0));
        chk("t6_wd",   64'(mem_wdata), 64'(0));
        chk("t6_be",   64'(mem_be), 64'(0));
        chk("t6_cnt",  64'(pixeles_escritos), 64'(0));
        tick(); tick();
        chk("t6_term", 64'(terminado), 64'(0));
        rst_n = 1'b1;
        tick();
        chk("t6_term_post", 64'(terminado), 64'(0));
        start_job(16'h0700, 20'd4);
        listo_in = 1'b1; pixel_in = 32'h0D0C0B0A;
        tick();
        listo_in = 1'b0;
        chk("t6_new_addr", 64'(mem_addr), 64'(16'h0700));
        chk("t6_new_wd",   64'(mem_wdata), 64'(32'h0D0C0B0A));
        chk("t6_new_be",   64'(mem_be), 64'(4'b1111));
        tick();
        chk("t6_new_term", 64'(terminado), 64'(1));
        chk("t6_new_cnt",  64'(pixeles_escritos), 64'(4));
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
